fir_dec_fifo: RTL and testbench
===============================

Name: fir_dec_fifo

Overview:
- Downstream stage of the 7-tap transposed FIR. Consumes its output word every enabled clock.
- Discards the FIR pipeline-fill samples after reset or clear, then decimates the stream by DECIM, either by picking one sample or by summing each group with saturation.
- Buffers results in a small FIFO with a valid/ready handshake toward the next consumer (DMA/bus interface).

Parameters:
- FILL, 7: number of enabled samples discarded after reset/Clr (FIR fill latency); 0..255.
- DECIM, 4: decimation factor; 1..16.
- MODE, 0: 0 = pick first sample of each group; 1 = saturating sum of DECIM samples.
- DEPTH, 4: FIFO entries; power of 2, ≥2.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- En  in  1  Yin is a valid sample this cycle.
- Yin  in  16  FIR output word, unsigned.
- Clr  in  1  synchronous flush/restart.
- Dout_ready  in  1  consumer accepts head word.
- Dout_valid  out  1  FIFO non-empty.
- Dout  out  16  FIFO head word.
- Count  out  log2(DEPTH)+1  current FIFO occupancy.
- Ovf  out  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset (Rst_n=0, async):
  - State=WARM; fill counter, phase, accumulator, read/write pointers, Count = 0.
  - Dout_valid=0, Ovf=0, Dout=0.
- State WARM:
  - Each En cycle increments the fill counter; the sample is discarded.
  - On the cycle where the FILLth discarded sample is taken, go to RUN. The next En sample is group sample 0.
  - FILL=0: reset enters RUN directly.
- State RUN:
  - Phase counter 0..DECIM-1 advances only on En and wraps to 0 after DECIM-1.
  - MODE 0: the sample at phase 0 is the result, pushed in that same cycle.
  - MODE 1: accumulator (17-bit internal) loads Yin at phase 0 and adds Yin at each later phase.
    - On the phase DECIM-1 sample, the result is min(acc+Yin, 0xFFFF) and is pushed that cycle; the accumulator restarts at the next phase 0.
    - DECIM=1: result = Yin.
  - En=0 holds all counters and the accumulator.
- FIFO:
  - Write occurs on the result cycle; data is visible on Dout the next cycle. No combinational bypass.
  - Dout = mem[rd_ptr], combinational from registered storage. Dout_valid = (Count≠0).
  - Pop occurs when Dout_valid && Dout_ready at the rising edge.
  - Push and pop in the same cycle: both happen; Count unchanged. When full, the pop frees the slot and the push is accepted (no drop).
  - Push while full without pop: result dropped, Ovf←1, pointers unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo DEPTH.
- Clr (synchronous, highest priority):
  - Empties the FIFO, clears Ovf, accumulator, phase and fill counter, and returns to WARM (RUN if FILL=0).
  - The sample presented in the Clr cycle is ignored.
  - Any push or pop in the Clr cycle is discarded.
- Async reset asserted mid-group or mid-transfer: everything returns to reset values immediately; partial sums are lost.
- Ovf stays 1 until Clr or reset.
- Dout_valid/Dout must stay stable while Dout_valid=1 and Dout_ready=0. Throughput is 1 push + 1 pop per cycle.

Test Plan:
- FILL=7, DECIM=4, MODE=0, En=1, Yin=n at cycle n from reset release, Dout_ready=1 → Dout_valid first rises the cycle after n=7 with Dout=7; subsequent pushes are 11, 15, 19; nothing from n=0..6 appears.
- MODE=1, same stimulus → first Dout=7+8+9+10=34, next 11+12+13+14=50. Then Yin held at 0x8000 → group sum saturates, Dout=0xFFFF.
- MODE=0, Dout_ready=0 → 7, 11, 15, 19 stored with Count=4; result 23 dropped and Ovf=1. Raise Dout_ready → drains 7, 11, 15, 19 in order, Ovf stays 1.
- FIFO full (Count=4) with Dout_ready=1 held through the next result cycle → pop and push occur together, Count stays 4, no drop, Ovf remains 0.
- En toggling 1/0 every cycle with MODE=0, DECIM=4 → only enabled samples are counted; kept values are the 8th, 12th, … enabled samples.
- Clr pulse with Count=3 and mid-group (phase 2) → next cycle Count=0, Dout_valid=0, Ovf=0; 7 enabled samples are discarded again before the next push. Repeat with Rst_n pulsed low mid-group instead → outputs go to reset values immediately, asynchronously.

Source files
------------

// File: rtl/fir_dec_fifo.sv
// FIR output post-processor: drops pipeline-fill samples, decimates (pick or saturating sum), buffers results.
// Result is visible on Dout one cycle after its last sample; if the FIFO is full and not popping, the result is dropped and Ovf latches.

module fir_dec_fifo_buf #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push_vld,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop_rdy,
   output logic                     out_vld,
   output logic [W-1:0]             out_dat,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push, pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      push     = 1'b0;
      pop      = 1'b0;
      drop     = 1'b0;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         pop  = (cnt_q != '0) && pop_rdy;
         // A pop in the same cycle frees the slot, so a full FIFO still accepts.
         push = push_vld && ((cnt_q != FULL_CNT) || pop);
         drop = push_vld && !push;
         if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      cnt_d = cnt_q + 1'b1;
         else if (pop && !push) cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_vld = (cnt_q != '0);
   assign out_dat = out_vld ? mem_q[rd_ptr_q] : '0;
   assign count   = cnt_q;
endmodule

module fir_dec_fifo #(
   parameter int FILL  = 7,
   parameter int DECIM = 4,
   parameter int MODE  = 0,
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic                     En,
   input  logic [15:0]              Yin,
   input  logic                     Clr,
   input  logic                     Dout_ready,
   output logic                     Dout_valid,
   output logic [15:0]              Dout,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Ovf
);
   typedef enum logic {WARM, RUN} state_t;
   localparam state_t     START     = (FILL == 0) ? RUN : WARM;
   localparam logic [7:0] FILL_LAST = 8'(FILL - 1);
   localparam logic [3:0] PH_LAST   = 4'(DECIM - 1);

   state_t      state_q, state_d;
   logic [7:0]  fill_q, fill_d;
   logic [3:0]  phase_q, phase_d;
   logic [16:0] acc_q, acc_d;
   logic        ovf_q, ovf_d;
   logic [16:0] sum;
   logic        res_vld;
   logic [15:0] res_dat;
   logic        drop;

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      phase_d = phase_q;
      acc_d   = acc_q;
      sum     = '0;
      res_vld = 1'b0;
      res_dat = '0;
      if (Clr) begin
         state_d = START;
         fill_d  = '0;
         phase_d = '0;
         acc_d   = '0;
      end else if (En) begin
         case (state_q)
            WARM: begin
               if (fill_q == FILL_LAST) begin
                  state_d = RUN;
                  fill_d  = '0;
               end else begin
                  fill_d = fill_q + 1'b1;
               end
            end
            RUN: begin
               sum     = ((phase_q == '0) ? 17'd0 : acc_q) + {1'b0, Yin};
               // Clamp the running sum so later adds can never wrap 17 bits.
               acc_d   = sum[16] ? 17'h10000 : sum;
               phase_d = (phase_q == PH_LAST) ? 4'd0 : phase_q + 1'b1;
               if (MODE == 0) begin
                  res_vld = (phase_q == '0);
                  res_dat = Yin;
               end else begin
                  res_vld = (phase_q == PH_LAST);
                  res_dat = sum[16] ? 16'hFFFF : sum[15:0];
               end
            end
            default: state_d = START;
         endcase
      end
   end

   always_comb begin
      ovf_d = Clr ? 1'b0 : (ovf_q | drop);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= START;
         fill_q  <= '0;
         phase_q <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         phase_q <= phase_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end

   fir_dec_fifo_buf #(.W(16), .DEPTH(DEPTH)) u_buf (
      .clk      (Clk),
      .rst_n    (Rst_n),
      .clr      (Clr),
      .push_vld (res_vld),
      .push_dat (res_dat),
      .pop_rdy  (Dout_ready),
      .out_vld  (Dout_valid),
      .out_dat  (Dout),
      .count    (Count),
      .drop     (drop)
   );

   assign Ovf = ovf_q;
endmodule

// File: tb/tb_fir_dec_fifo.sv
// Directed bench: a pick-mode and a sum-mode instance share one stimulus stream.

module tb_fir_dec_fifo;
   logic        Clk, Rst_n, En, Clr, Dout_ready;
   logic [15:0] Yin;
   logic        dv0, dv1, ovf0, ovf1;
   logic [15:0] d0, d1;
   logic [2:0]  cnt0, cnt1;
   int          checks = 0;
   int          errors = 0;

   fir_dec_fifo #(.FILL(7), .DECIM(4), .MODE(0), .DEPTH(4)) u_dut0 (
      .Clk(Clk), .Rst_n(Rst_n), .En(En), .Yin(Yin), .Clr(Clr), .Dout_ready(Dout_ready),
      .Dout_valid(dv0), .Dout(d0), .Count(cnt0), .Ovf(ovf0)
   );

   fir_dec_fifo #(.FILL(7), .DECIM(4), .MODE(1), .DEPTH(4)) u_dut1 (
      .Clk(Clk), .Rst_n(Rst_n), .En(En), .Yin(Yin), .Clr(Clr), .Dout_ready(Dout_ready),
      .Dout_valid(dv1), .Dout(d1), .Count(cnt1), .Ovf(ovf1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Rst_n = 1'b1; En = 1'b0; Yin = '0; Clr = 1'b0; Dout_ready = 1'b1;
      #1 Rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(dv0), 32'd0);
      chk("rst_count", 32'(cnt0), 32'd0);
      chk("rst_ovf", 32'(ovf0), 32'd0);
      chk("rst_dout", 32'(d0), 32'd0);
      chk("rst_valid1", 32'(dv1), 32'd0);
      step(); step();
      Rst_n = 1'b1; En = 1'b1;

      // Yin = n on enabled edge n after reset release
      for (int n = 0; n <= 22; n++) begin
         Yin = (n <= 19) ? 16'(n) : 16'h8000;
         step();
         case (n)
            6:  begin chk("fill_valid", 32'(dv0), 32'd0); chk("fill_count", 32'(cnt0), 32'd0); end
            7:  begin chk("first_valid", 32'(dv0), 32'd1); chk("first_dout", 32'(d0), 32'd7);
                      chk("first_count", 32'(cnt0), 32'd1); end
            8:  chk("popped_valid", 32'(dv0), 32'd0);
            10: chk("sum_34", 32'(d1), 32'd34);
            11: chk("pick_11", 32'(d0), 32'd11);
            14: chk("sum_50", 32'(d1), 32'd50);
            15: chk("pick_15", 32'(d0), 32'd15);
            18: chk("sum_66", 32'(d1), 32'd66);
            19: chk("pick_19", 32'(d0), 32'd19);
            22: begin chk("sum_sat", 32'(d1), 32'hFFFF); chk("sum_sat_vld", 32'(dv1), 32'd1); end
            default: ;
         endcase
      end

      // Overflow with consumer stalled
      Clr = 1'b1; Yin = 16'hAAAA; Dout_ready = 1'b0;
      step();
      Clr = 1'b0;
      chk("clr_count", 32'(cnt0), 32'd0);
      for (int k = 0; k <= 23; k++) begin
         Yin = 16'(k);
         step();
         if (k == 19) begin chk("full_count", 32'(cnt0), 32'd4); chk("full_ovf", 32'(ovf0), 32'd0); end
         if (k == 23) begin
            chk("drop_count", 32'(cnt0), 32'd4);
            chk("drop_ovf", 32'(ovf0), 32'd1);
            chk("drop_head", 32'(d0), 32'd7);
         end
      end
      En = 1'b0; Dout_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("drain_dout", 32'(d0), 32'(7 + 4 * i));
         chk("drain_count", 32'(cnt0), 32'(4 - i));
      end
      step();
      chk("drain_empty", 32'(dv0), 32'd0);
      chk("ovf_sticky", 32'(ovf0), 32'd1);

      // Push and pop together while full
      Clr = 1'b1; En = 1'b1; Dout_ready = 1'b0;
      step();
      Clr = 1'b0;
      chk("clr_ovf", 32'(ovf0), 32'd0);
      for (int k = 0; k <= 23; k++) begin
         Yin = 16'(k);
         Dout_ready = (k == 23);
         step();
         if (k == 19) chk("pp_full", 32'(cnt0), 32'd4);
         if (k == 23) begin
            chk("pp_count", 32'(cnt0), 32'd4);
            chk("pp_ovf", 32'(ovf0), 32'd0);
            chk("pp_head", 32'(d0), 32'd11);
         end
      end
      En = 1'b0; Dout_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("pp_drain", 32'(d0), 32'(11 + 4 * i));
      end
      step();
      chk("pp_empty", 32'(dv0), 32'd0);

      // En toggling: only enabled samples are counted
      Clr = 1'b1; En = 1'b1;
      step();
      Clr = 1'b0;
      for (int j = 0; j <= 22; j++) begin
         En = (j % 2 == 0);
         Yin = 16'(j + 100);
         step();
         if (j == 13) chk("tog_fill", 32'(dv0), 32'd0);
         if (j == 14) begin chk("tog_8th", 32'(d0), 32'd114); chk("tog_vld", 32'(dv0), 32'd1); end
         if (j == 15) chk("tog_pop", 32'(dv0), 32'd0);
         if (j == 22) chk("tog_12th", 32'(d0), 32'd122);
      end

      // Clr mid-group with three entries buffered
      Clr = 1'b1; En = 1'b1;
      step();
      Clr = 1'b0; Dout_ready = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         Yin = 16'(k);
         step();
      end
      chk("pre_clr_count", 32'(cnt0), 32'd3);
      Clr = 1'b1;
      step();
      Clr = 1'b0;
      chk("mclr_count", 32'(cnt0), 32'd0);
      chk("mclr_valid", 32'(dv0), 32'd0);
      chk("mclr_ovf", 32'(ovf0), 32'd0);
      chk("mclr_dout", 32'(d0), 32'd0);
      for (int k = 0; k <= 16; k++) begin
         Dout_ready = (k < 8);
         Yin = 16'(k + 200);
         step();
         if (k == 6)  chk("refill_valid", 32'(dv0), 32'd0);
         if (k == 7)  chk("refill_dout", 32'(d0), 32'd207);
         if (k == 16) chk("pre_rst_count", 32'(cnt0), 32'd3);
      end

      // Async reset mid-group, away from the clock edge
      #3 Rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(cnt0), 32'd0);
      chk("arst_valid", 32'(dv0), 32'd0);
      chk("arst_dout", 32'(d0), 32'd0);
      chk("arst_ovf", 32'(ovf0), 32'd0);
      chk("arst_valid1", 32'(dv1), 32'd0);
      step();
      Rst_n = 1'b1; En = 1'b1; Dout_ready = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         Yin = 16'(k + 300);
         step();
         if (k == 6)  chk("post_rst_fill", 32'(dv0), 32'd0);
         if (k == 7)  chk("post_rst_dout", 32'(d0), 32'd307);
         if (k == 10) chk("post_rst_sum", 32'(d1), 32'd1234);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
